// File: rtl/conv3x3_window_gen_pkg.sv
// rtl/conv3x3_window_gen_pkg.sv - shared widths and helpers for the 3x3 window generator
package conv3x3_window_gen_pkg;

    // Pixel width shared with the downstream ternary adder.
    localparam int DATA_W_DEF = 6;
    localparam int IMG_W_DEF  = 8;
    localparam int IMG_H_DEF  = 8;

    // Counter width for a 0..n-1 range; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int COL_W_DEF = cnt_w(IMG_W_DEF);
    localparam int ROW_W_DEF = cnt_w(IMG_H_DEF);

endpackage

// File: rtl/conv3x3_window_gen_if.sv
// rtl/conv3x3_window_gen_if.sv - pixel stream in, 3x3 window out
import conv3x3_window_gen_pkg::*;

interface conv3x3_window_gen_if #(
    parameter int DATA_W = conv3x3_window_gen_pkg::DATA_W_DEF
);
    logic              frame_start;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic [DATA_W-1:0] x11, x12, x13;
    logic [DATA_W-1:0] x21, x22, x23;
    logic [DATA_W-1:0] x31, x32, x33;
    logic              fire;
    logic              frame_done;

    modport master (
        output frame_start, in_valid, in_data,
        input  x11, x12, x13, x21, x22, x23, x31, x32, x33, fire, frame_done
    );

    modport slave (
        input  frame_start, in_valid, in_data,
        output x11, x12, x13, x21, x22, x23, x31, x32, x33, fire, frame_done
    );
endinterface

// File: rtl/conv3x3_window_gen_line_buffer.sv
// rtl/conv3x3_window_gen_line_buffer.sv - one image row of pixels, read-before-write
import conv3x3_window_gen_pkg::*;

module conv_line_buffer #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = IMG_W_DEF,
    parameter int IDX_W  = cnt_w(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    // Contents are never reset: the row gate upstream hides stale data.
    logic [DATA_W-1:0] mem_q [DEPTH];

    assign rdata_o = mem_q[idx_i];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

endmodule

// File: rtl/conv3x3_window_gen.sv
// rtl/conv3x3_window_gen.sv - streaming 3x3 neighbourhood generator (valid convolution, no padding)
import conv3x3_window_gen_pkg::*;

module conv3x3_window_gen #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int IMG_W  = IMG_W_DEF,
    parameter int IMG_H  = IMG_H_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    conv3x3_window_gen_if.slave  s_if
);

    localparam int COL_W = cnt_w(IMG_W);
    localparam int ROW_W = cnt_w(IMG_H);

    logic [COL_W-1:0]  col_q, col_d, cur_col;
    logic [ROW_W-1:0]  row_q, row_d, cur_row;
    logic              fire_q, fire_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] win_q [3][3];
    logic [DATA_W-1:0] win_d [3][3];
    logic [DATA_W-1:0] lb0_rd, lb1_rd;

    // lb0 holds the previous row, lb1 the one before it.
    conv_line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W), .IDX_W(COL_W)) u_lb0 (
        .clk     (clk),
        .we_i    (s_if.in_valid),
        .idx_i   (cur_col),
        .wdata_i (s_if.in_data),
        .rdata_o (lb0_rd)
    );

    conv_line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W), .IDX_W(COL_W)) u_lb1 (
        .clk     (clk),
        .we_i    (s_if.in_valid),
        .idx_i   (cur_col),
        .wdata_i (lb0_rd),
        .rdata_o (lb1_rd)
    );

    // frame_start overrides the stored position for this cycle's pixel.
    always_comb begin
        cur_col = s_if.frame_start ? '0 : col_q;
        cur_row = s_if.frame_start ? '0 : row_q;
        col_d   = cur_col;
        row_d   = cur_row;
        fire_d  = 1'b0;
        done_d  = 1'b0;
        if (s_if.in_valid) begin
            if (cur_col == COL_W'(IMG_W - 1)) begin
                col_d = '0;
                row_d = (cur_row == ROW_W'(IMG_H - 1)) ? '0 : cur_row + ROW_W'(1);
            end else begin
                col_d = cur_col + COL_W'(1);
            end
            fire_d = (cur_row >= ROW_W'(2)) && (cur_col >= COL_W'(2));
            done_d = fire_d && (cur_row == ROW_W'(IMG_H - 1))
                            && (cur_col == COL_W'(IMG_W - 1));
        end
    end

    always_comb begin
        win_d = win_q;
        if (s_if.in_valid) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = lb1_rd;
            win_d[1][2] = lb0_rd;
            win_d[2][2] = s_if.in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q  <= '0;
            row_q  <= '0;
            fire_q <= 1'b0;
            done_q <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            fire_q <= fire_d;
            done_q <= done_d;
            win_q  <= win_d;
        end
    end

    assign s_if.x11        = win_q[0][0];
    assign s_if.x12        = win_q[0][1];
    assign s_if.x13        = win_q[0][2];
    assign s_if.x21        = win_q[1][0];
    assign s_if.x22        = win_q[1][1];
    assign s_if.x23        = win_q[1][2];
    assign s_if.x31        = win_q[2][0];
    assign s_if.x32        = win_q[2][1];
    assign s_if.x33        = win_q[2][2];
    assign s_if.fire       = fire_q;
    assign s_if.frame_done = done_q;

endmodule

// File: tb/tb_conv3x3_window_gen.sv
// tb/tb_conv3x3_window_gen.sv - directed checks for a 4x4 and a 5x3 window generator
import conv3x3_window_gen_pkg::*;

module tb_conv3x3_window_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    conv3x3_window_gen_if #(.DATA_W(6)) ifa ();
    conv3x3_window_gen_if #(.DATA_W(6)) ifb ();

    conv3x3_window_gen #(.DATA_W(6), .IMG_W(4), .IMG_H(4)) dut_a (
        .clk  (clk),
        .rst  (rst),
        .s_if (ifa)
    );

    conv3x3_window_gen #(.DATA_W(6), .IMG_W(5), .IMG_H(3)) dut_b (
        .clk  (clk),
        .rst  (rst),
        .s_if (ifb)
    );

    // Image model: what the bench sent at each (row, col) of each DUT.
    int          img [2][8][8];
    int          tr [2];
    int          tc [2];
    logic [53:0] fired_q [$];

    function automatic logic [53:0] pack9(input int a, input int b, input int c,
                                          input int d, input int e, input int f,
                                          input int g, input int h, input int i);
        return {6'(a), 6'(b), 6'(c), 6'(d), 6'(e), 6'(f), 6'(g), 6'(h), 6'(i)};
    endfunction

    function automatic logic [53:0] obs_win(input bit sel);
        if (sel)
            return {ifb.x11, ifb.x12, ifb.x13, ifb.x21, ifb.x22, ifb.x23, ifb.x31, ifb.x32, ifb.x33};
        return {ifa.x11, ifa.x12, ifa.x13, ifa.x21, ifa.x22, ifa.x23, ifa.x31, ifa.x32, ifa.x33};
    endfunction

    function automatic logic obs_fire(input bit sel);
        return sel ? ifb.fire : ifa.fire;
    endfunction

    function automatic logic obs_done(input bit sel);
        return sel ? ifb.frame_done : ifa.frame_done;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_idle();
        ifa.in_valid = 1'b0; ifa.frame_start = 1'b0; ifa.in_data = '0;
        ifb.in_valid = 1'b0; ifb.frame_start = 1'b0; ifb.in_data = '0;
    endtask

    // Called at a negedge; the pixel is taken on the next posedge and checked at the following negedge.
    task automatic send(input bit sel, input int v, input bit fs);
        int w, h, r, c;
        bit ef, ed;
        logic [53:0] ew;
        w = sel ? 5 : 4;
        h = sel ? 3 : 4;
        if (fs) begin
            tr[sel] = 0;
            tc[sel] = 0;
        end
        r = tr[sel];
        c = tc[sel];
        if (sel) begin
            ifb.in_valid = 1'b1; ifb.frame_start = fs; ifb.in_data = 6'(v);
        end else begin
            ifa.in_valid = 1'b1; ifa.frame_start = fs; ifa.in_data = 6'(v);
        end
        img[sel][r][c] = v;
        ef = (r >= 2) && (c >= 2);
        ed = ef && (r == h - 1) && (c == w - 1);
        ew = '0;
        if (ef)
            ew = pack9(img[sel][r-2][c-2], img[sel][r-2][c-1], img[sel][r-2][c],
                       img[sel][r-1][c-2], img[sel][r-1][c-1], img[sel][r-1][c],
                       img[sel][r][c-2],   img[sel][r][c-1],   img[sel][r][c]);
        @(negedge clk);
        drive_idle();
        chk("fire", 64'(obs_fire(sel)), 64'(ef));
        chk("frame_done", 64'(obs_done(sel)), 64'(ed));
        if (ef) chk("window", 64'(obs_win(sel)), 64'(ew));
        if (obs_fire(sel)) fired_q.push_back(obs_win(sel));
        if (c == w - 1) begin
            tc[sel] = 0;
            tr[sel] = (r == h - 1) ? 0 : r + 1;
        end else begin
            tc[sel] = c + 1;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            drive_idle();
            @(negedge clk);
            chk("idle_fire", 64'(ifa.fire), 64'd0);
            chk("idle_done", 64'(ifa.frame_done), 64'd0);
        end
    endtask

    task automatic chk_frame1(input string tag);
        chk({tag, "_nfires"}, 64'(fired_q.size()), 64'd4);
        if (fired_q.size() == 4) begin
            chk({tag, "_first"}, 64'(fired_q[0]), 64'(pack9(1, 2, 3, 5, 6, 7, 9, 10, 11)));
            chk({tag, "_last"},  64'(fired_q[3]), 64'(pack9(6, 7, 8, 10, 11, 12, 14, 15, 16)));
        end
    endtask

    initial begin
        drive_idle();
        tr[0] = 0; tc[0] = 0; tr[1] = 0; tc[1] = 0;
        @(negedge clk);
        chk("rst_win_a",  64'(obs_win(0)), 64'd0);
        chk("rst_fire_a", 64'(ifa.fire), 64'd0);
        chk("rst_done_a", 64'(ifa.frame_done), 64'd0);
        chk("rst_win_b",  64'(obs_win(1)), 64'd0);
        chk("rst_fire_b", 64'(ifb.fire), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1: continuous frame
        fired_q.delete();
        for (int i = 1; i <= 16; i++) send(0, i, i == 1);
        chk_frame1("t1");

        // 2: idle gaps of 1..3 cycles between pixels
        fired_q.delete();
        for (int i = 1; i <= 16; i++) begin
            send(0, i, 1'b0);
            idle((i % 3) + 1);
        end
        chk_frame1("t2");

        // 3: two frames back to back, second frame values truncate to 6 bits
        fired_q.delete();
        for (int i = 1; i <= 16; i++) send(0, i, 1'b0);
        for (int i = 101; i <= 116; i++) send(0, i, 1'b0);
        chk("t3_nfires", 64'(fired_q.size()), 64'd8);
        if (fired_q.size() == 8)
            chk("t3_f2_first", 64'(fired_q[4]), 64'(pack9(101, 102, 103, 105, 106, 107, 109, 110, 111)));

        // 4: reset mid-frame after pixel 7
        for (int i = 1; i <= 7; i++) send(0, i, 1'b0);
        rst = 1'b1;
        #1;
        chk("t4_rst_win",  64'(obs_win(0)), 64'd0);
        chk("t4_rst_fire", 64'(ifa.fire), 64'd0);
        @(negedge clk);
        chk("t4_rst_win2", 64'(obs_win(0)), 64'd0);
        rst = 1'b0;
        tr[0] = 0; tc[0] = 0; tr[1] = 0; tc[1] = 0;
        @(negedge clk);
        fired_q.delete();
        for (int i = 1; i <= 16; i++) send(0, i, 1'b0);
        chk_frame1("t4");

        // 5: junk then frame_start resync
        fired_q.delete();
        for (int i = 0; i < 6; i++) send(0, 50 + i, 1'b0);
        for (int i = 1; i <= 16; i++) send(0, i, i == 1);
        chk_frame1("t5");

        // 6: 5x3 image
        fired_q.delete();
        for (int i = 1; i <= 15; i++) send(1, i, i == 1);
        chk("t6_nfires", 64'(fired_q.size()), 64'd3);
        if (fired_q.size() == 3) begin
            chk("t6_x33_0", 64'(fired_q[0][5:0]), 64'd13);
            chk("t6_x33_1", 64'(fired_q[1][5:0]), 64'd14);
            chk("t6_x33_2", 64'(fired_q[2][5:0]), 64'd15);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
